step_executor: RTL and testbench
================================

Name: step_executor

Overview:
- Execution end of the program-counter handshake. Accepts one-cycle `set` / `delay` strobes from the instruction decoder.
- A `set` drives the valve register, waits a fixed settle time, then returns `set_done`.
- A `delay` counts a programmed number of time ticks, then returns `count_done`.
- Both done pulses feed the program counter, which advances on them. Sits between the decoder/instruction memory and the valve output pins.

Parameters:
- VALVES, 8, number of valve outputs / width of valve mask
- DLY_W, 16, width of delay operand in ticks
- TICK_DIV, 100000, clock cycles per delay tick (>=1)
- SETTLE, 4, clock cycles from valve update to set_done (>=1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- set  in  1  one-cycle strobe: apply valve_mask
- delay  in  1  one-cycle strobe: wait delay_len ticks
- valve_mask  in  VALVES  valve pattern, sampled with set
- delay_len  in  DLY_W  tick count, sampled with delay
- set_done  out  1  one-cycle pulse, valve step complete
- count_done  out  1  one-cycle pulse, delay step complete
- valves  out  VALVES  registered valve drive
- busy  out  1  high while a step is in progress
- err  out  1  sticky protocol-error flag

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: valves=0, set_done=0, count_done=0, busy=0, err=0, state=IDLE, all counters=0. Reset mid-step aborts the step, and no done pulse is issued.
- States: IDLE, SETTLE, COUNT, DONE_SET, DONE_CNT.
- IDLE + set sampled at edge k:
  - valves<=valve_mask at edge k; busy=1 from edge k; enter SETTLE.
  - set_done is high for exactly the cycle after edge k+SETTLE (DONE_SET), busy=0 in that cycle, then IDLE.
- IDLE + delay sampled at edge k:
  - latch N=delay_len, busy=1, enter COUNT.
  - Prescaler counts 0..TICK_DIV-1; each wrap decrements the tick counter.
  - count_done is high for exactly the cycle after edge k+N*TICK_DIV (DONE_CNT), busy=0 in that cycle.
- N=0: count_done is high the cycle after edge k+1 (minimum latency 1). The tick counter never wraps below zero.
- Simultaneous set and delay in IDLE: set executes, delay is dropped, err<=1.
- Strobe while SETTLE or COUNT: ignored, err<=1, the current step is unaffected.
- Strobe during a DONE_* cycle: accepted as a new step (busy=0 there). This permits back-to-back steps with one idle-free cycle.
- valves holds its value through delay steps and changes only on an accepted set.
- set_done and count_done are never high simultaneously and never longer than 1 cycle.
- err clears only on rst.
- Arithmetic: prescaler width clog2(TICK_DIV), min 1. Tick counter width DLY_W. Settle counter width clog2(SETTLE+1). No overflow is possible since counters only decrement to 0 or wrap at TICK_DIV-1.

Decomposition:
- Shared package `mfc_pkg`:
  - state enum (IDLE, SETTLE, COUNT, DONE_SET, DONE_CNT)
  - default VALVES / DLY_W constants, also used by pc and the decoder
  - opcode constants for SET / DELAY
- One natural sub-module: `tick_prescaler`. It takes parameter TICK_DIV and a synchronous clear, and outputs a one-cycle `tick` pulse every TICK_DIV cycles while enabled. It is instantiated for the COUNT state.

Test Plan:
- Bench parameters: TICK_DIV=4, SETTLE=4, VALVES=8.
- Reset release, no strobes -> valves=0x00, busy=0, err=0, set_done=count_done=0 for 20 cycles.
- set with valve_mask=0xA5 at edge 0 -> valves=0xA5 after edge 0; busy=1 edges 0..3; set_done=1 only in the cycle after edge 4; err=0.
- delay with delay_len=3 at edge 0 -> count_done=1 only in the cycle after edge 12; valves unchanged. Repeat with delay_len=0 -> count_done in the cycle after edge 1.
- set and delay asserted in the same cycle (mask 0x0F) -> valves=0x0F, set_done after SETTLE, no count_done ever, err=1 and stays 1.
- delay_len=5 started, then set (mask 0xFF) strobed 3 cycles later -> set ignored, valves unchanged, err=1, count_done still after edge 20.
- delay_len=10 started, rst asserted for 1 cycle at edge 6 -> no count_done, all outputs at reset values. A subsequent set with 0x3C completes normally with set_done after SETTLE.

Source files
------------

// File: rtl/mfc_pkg.sv
// Shared definitions for the manifold controller: the executor state
// encoding, the default datapath widths that the program counter and the
// instruction decoder also use, and the opcodes that produce the
// set / delay strobes.
package mfc_pkg;

  localparam int DEF_VALVES = 8;
  localparam int DEF_DLY_W  = 16;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_SET   = 2'd1,
    OP_DELAY = 2'd2
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_COUNT    = 3'd2,
    ST_DONE_SET = 3'd3,
    ST_DONE_CNT = 3'd4
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to delay ticks.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : synchronous clear, restarts the division at phase 0
//   en   : count enable
//   tick : one-cycle pulse on the last cycle of every TICK_DIV enabled cycles
module tick_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] phase;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + PW'(1);
    end
  end

  // The tick is consumed on the edge that ends the TICK_DIV-th cycle.
  assign tick = en && (phase == LAST);

endmodule

// File: rtl/step_executor.sv
// Executes set / delay steps for the program counter.
//   clk, rst   : system clock, synchronous active-high reset
//   set        : strobe, drive valve_mask onto the valves then settle
//   delay      : strobe, wait delay_len ticks of TICK_DIV cycles
//   valve_mask : valve pattern, sampled with set
//   delay_len  : tick count, sampled with delay
//   set_done   : one-cycle pulse when the settle time has elapsed
//   count_done : one-cycle pulse when the delay has elapsed
//   valves     : registered valve drive
//   busy       : step in progress (low during the done cycle)
//   err        : sticky, set by strobes that cannot be honoured
module step_executor
  import mfc_pkg::*;
#(
  parameter int VALVES   = DEF_VALVES,
  parameter int DLY_W    = DEF_DLY_W,
  parameter int TICK_DIV = 100000,
  parameter int SETTLE   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic              delay,
  input  logic [VALVES-1:0] valve_mask,
  input  logic [DLY_W-1:0]  delay_len,
  output logic              set_done,
  output logic              count_done,
  output logic [VALVES-1:0] valves,
  output logic              busy,
  output logic              err
);

  localparam int SW = $clog2(SETTLE + 1);
  // Settle counter runs SETTLE-1 down to 0, so SETTLE cycles are spent in
  // ST_SETTLE before the done cycle.
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

  state_t            state;
  logic [SW-1:0]     settle_cnt;
  logic [DLY_W-1:0]  tick_cnt;
  logic              counting;
  logic              tick;

  assign counting = (state == ST_COUNT);

  // Held in clear outside ST_COUNT so every delay starts at phase 0.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (!counting),
    .en   (counting),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      tick_cnt   <= '0;
      valves     <= '0;
      set_done   <= 1'b0;
      count_done <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      set_done   <= 1'b0;
      count_done <= 1'b0;

      case (state)
        // The done cycles accept a new step exactly like idle, which lets
        // the program counter issue steps back to back.
        ST_IDLE, ST_DONE_SET, ST_DONE_CNT: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (set) begin
            valves     <= valve_mask;
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_SETTLE;
            busy       <= 1'b1;
            // A simultaneous delay is dropped and flagged.
            if (delay) err <= 1'b1;
          end else if (delay) begin
            tick_cnt <= delay_len;
            state    <= ST_COUNT;
            busy     <= 1'b1;
          end
        end

        ST_SETTLE: begin
          if (set || delay) err <= 1'b1;
          if (settle_cnt == '0) begin
            state    <= ST_DONE_SET;
            set_done <= 1'b1;
            busy     <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end

        ST_COUNT: begin
          if (set || delay) err <= 1'b1;
          // A zero-length delay finishes on the first edge in ST_COUNT;
          // otherwise the step ends on the tick that takes the count to 0.
          if (tick_cnt == '0) begin
            state      <= ST_DONE_CNT;
            count_done <= 1'b1;
            busy       <= 1'b0;
          end else if (tick) begin
            tick_cnt <= tick_cnt - DLY_W'(1);
            if (tick_cnt == DLY_W'(1)) begin
              state      <= ST_DONE_CNT;
              count_done <= 1'b1;
              busy       <= 1'b0;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_executor.sv
module tb_step_executor;

  localparam int VALVES   = 8;
  localparam int DLY_W    = 16;
  localparam int TICK_DIV = 4;
  localparam int SETTLE   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              set = 1'b0;
  logic              delay = 1'b0;
  logic [VALVES-1:0] valve_mask = '0;
  logic [DLY_W-1:0]  delay_len = '0;
  logic              set_done;
  logic              count_done;
  logic [VALVES-1:0] valves;
  logic              busy;
  logic              err;

  step_executor #(
    .VALVES   (VALVES),
    .DLY_W    (DLY_W),
    .TICK_DIV (TICK_DIV),
    .SETTLE   (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .set        (set),
    .delay      (delay),
    .valve_mask (valve_mask),
    .delay_len  (delay_len),
    .set_done   (set_done),
    .count_done (count_done),
    .valves     (valves),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Behavioural model: a step is described by its kind and the edge after
  // which its done pulse is visible. Everything else follows arithmetically.
  int          edge_n = 0;
  int          m_kind = 0;        // 0 none, 1 set step, 2 delay step
  int          m_done_edge = -1;
  logic [7:0]  m_valves = '0;
  logic        m_err = 1'b0;
  logic        exp_busy, exp_sd, exp_cd;
  bit          checking = 1'b0;

  always @(posedge clk) begin
    bit busy_before;
    edge_n++;
    if (rst) begin
      m_kind = 0; m_done_edge = -1; m_valves = '0; m_err = 1'b0;
    end else begin
      busy_before = (m_kind != 0) && (edge_n - 1 < m_done_edge);
      if (busy_before) begin
        if (set || delay) m_err = 1'b1;
      end else if (set) begin
        m_valves = valve_mask;
        m_kind = 1;
        m_done_edge = edge_n + SETTLE;
        if (delay) m_err = 1'b1;
      end else if (delay) begin
        m_kind = 2;
        m_done_edge = edge_n + ((delay_len == 0) ? 1 : int'(delay_len) * TICK_DIV);
      end
    end
    exp_busy = (m_kind != 0) && (edge_n < m_done_edge);
    exp_sd   = (m_kind == 1) && (edge_n == m_done_edge);
    exp_cd   = (m_kind == 2) && (edge_n == m_done_edge);
  end

  // Compare process plus a pulse monitor used by the directed checks.
  int last_sd_edge = -1;
  int last_cd_edge = -1;
  int cd_count = 0;

  always @(negedge clk) begin
    if (checking) begin
      check("valves", 32'(valves), 32'(m_valves));
      check("busy", 32'(busy), 32'(exp_busy));
      check("set_done", 32'(set_done), 32'(exp_sd));
      check("count_done", 32'(count_done), 32'(exp_cd));
      check("err", 32'(err), 32'(m_err));
      if (set_done === 1'b1) last_sd_edge = edge_n;
      if (count_done === 1'b1) begin
        last_cd_edge = edge_n;
        cd_count++;
      end
    end
  end

  // Called at a negedge; returns the edge index that samples the strobe.
  task automatic strobe(input logic s, input logic d, input logic [7:0] m,
                        input logic [15:0] len, output int at);
    set = s; delay = d; valve_mask = m; delay_len = len;
    at = edge_n + 1;
    @(negedge clk);
    set = 1'b0; delay = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int s, cd_before, r;

    @(posedge clk);
    checking = 1'b1;
    @(negedge clk);
    idle(1);
    rst = 1'b0;

    // Quiet after reset.
    idle(20);
    check("reset_valves", 32'(valves), 32'h00);
    check("reset_busy", 32'(busy), 32'h0);

    // Plain set.
    strobe(1, 0, 8'hA5, 16'd0, s);
    check("set_busy_start", 32'(busy), 32'h1);
    check("set_valves", 32'(valves), 32'hA5);
    idle(8);
    check("set_done_edge", 32'(last_sd_edge), 32'(s + 4));
    check("set_err", 32'(err), 32'h0);

    // Delay of 3 ticks, then of 0 ticks.
    strobe(0, 1, 8'h00, 16'd3, s);
    check("model_delay3", 32'(m_done_edge), 32'(s + 12));
    idle(16);
    check("delay3_edge", 32'(last_cd_edge), 32'(s + 12));
    check("delay3_valves", 32'(valves), 32'hA5);
    strobe(0, 1, 8'h00, 16'd0, s);
    check("model_delay0", 32'(m_done_edge), 32'(s + 1));
    idle(4);
    check("delay0_edge", 32'(last_cd_edge), 32'(s + 1));

    // Simultaneous set and delay: set wins, delay dropped.
    cd_before = cd_count;
    strobe(1, 1, 8'h0F, 16'd2, s);
    idle(20);
    check("both_valves", 32'(valves), 32'h0F);
    check("both_sd_edge", 32'(last_sd_edge), 32'(s + 4));
    check("both_no_cd", 32'(cd_count), 32'(cd_before));
    check("both_err", 32'(err), 32'h1);

    // Set strobed during a delay is ignored.
    strobe(0, 1, 8'h00, 16'd5, s);
    idle(2);
    strobe(1, 0, 8'hFF, 16'd0, r);
    check("ignored_at", 32'(r), 32'(s + 3));
    idle(22);
    check("ignored_cd_edge", 32'(last_cd_edge), 32'(s + 20));
    check("ignored_valves", 32'(valves), 32'h0F);
    check("ignored_err", 32'(err), 32'h1);

    // Reset in the middle of a delay aborts it.
    strobe(0, 1, 8'h00, 16'd10, s);
    idle(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cd_before = cd_count;
    idle(50);
    check("abort_no_cd", 32'(cd_count), 32'(cd_before));
    check("abort_valves", 32'(valves), 32'h00);
    check("abort_err", 32'(err), 32'h0);
    strobe(1, 0, 8'h3C, 16'd0, s);
    idle(8);
    check("after_abort_sd", 32'(last_sd_edge), 32'(s + 4));
    check("after_abort_valves", 32'(valves), 32'h3C);

    // Randomised traffic, including back-to-back and colliding strobes.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      rst        = (r == 199);
      set        = (r < 14) || (r == 40);
      delay      = (r >= 10 && r < 24) || (r == 40);
      valve_mask = 8'($urandom);
      delay_len  = 16'($urandom_range(0, 6));
      @(negedge clk);
    end
    set = 1'b0; delay = 1'b0; rst = 1'b0;
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
